// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: the byte width and the
// send-sequencer state encoding.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with an explicit occupancy counter, registered
// full/empty/level flags and a sticky overflow flag.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              pop_ok;
    logic              push_ok;

    // A pop in the same cycle frees a slot, so a push at full still lands.
    always_comb begin
        pop_ok     = pop && !empty_q;
        push_ok    = push && (!full_q || pop_ok);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - COUNT_ONE;
        end
        full_d     = (count_d == COUNT_MAX);
        empty_d    = (count_d == '0);
        overflow_d = (push && !push_ok) || (overflow_q && !clr_ovf);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes from the register side and hands them one at a time to the
// UART transmitter, waiting for its active/done handshake between frames.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_active,
    input  logic              tx_done
);

    feeder_state_e     state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] head_data;
    logic              pop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head_data (head_data),
        .clr_ovf   (clr_ovf),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    // Completion only counts once the transmitter has gone active, so an idle
    // transmitter's standing done flag cannot end a frame early.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop       = 1'b1;
                tx_data_d = head_data;
                state_d   = SEND;
            end
            SEND: begin
                if (tx_active) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done && !tx_active) begin
                    state_d = (enable && !empty) ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_send = (state_q == SEND);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder with a behavioural
// transmitter responder and a byte-order reference queue.
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable  = 1'b0;
    logic              wr_en   = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              busy;
    logic              tx_send;
    logic              tx_active;
    logic              tx_done;
    logic [ADDR_W:0]   level;
    logic [7:0]        tx_data;

    int                tests_run    = 0;
    int                tests_failed = 0;
    logic [7:0]        exp_q[$];
    logic [7:0]        rx_q[$];
    int                resp_phase;
    int                resp_cnt;
    logic [7:0]        resp_byte;

    uart_tx_feeder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || !empty || tx_active) && n < 3000) begin
            tick();
            n++;
        end
        check_output(tag, {29'd0, busy, !empty, tx_active}, 32'd0);
    endtask

    task automatic check_rx(input string tag);
        check_output({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check_output($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Transmitter model: idle shows done=1; two cycles after seeing send it goes
    // active for a random frame length, then returns to idle.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_active  <= 1'b0;
            tx_done    <= 1'b1;
            resp_phase <= 0;
            resp_cnt   <= 0;
            resp_byte  <= 8'h00;
        end else begin
            case (resp_phase)
                0: if (tx_send) resp_phase <= 1;
                1: begin
                    tx_active  <= 1'b1;
                    tx_done    <= 1'b0;
                    resp_byte  <= tx_data;
                    rx_q.push_back(tx_data);
                    resp_cnt   <= int'($urandom_range(3, 8));
                    resp_phase <= 2;
                end
                default: begin
                    if (resp_cnt <= 1) begin
                        tx_active  <= 1'b0;
                        tx_done    <= 1'b1;
                        resp_phase <= 0;
                    end else begin
                        resp_cnt <= resp_cnt - 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (reset_n && resp_phase == 2) begin
            check_output("tx_data_hold", {24'd0, tx_data}, {24'd0, resp_byte});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] b;

        // Reset and idle behaviour
        tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check_output("rst_empty", empty, 1);
        check_output("rst_full", full, 0);
        check_output("rst_level", level, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_tx_send", tx_send, 0);
        check_output("rst_tx_data", tx_data, 8'h00);
        check_output("rst_busy", busy, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("idle_no_send", tx_send, 0);
            check_output("idle_busy", busy, 0);
        end

        // Single byte latency and handshake
        push(8'hA5);
        exp_q.push_back(8'hA5);
        check_output("single_e0_send", tx_send, 0);
        check_output("single_e0_level", level, 1);
        check_output("single_e0_empty", empty, 0);
        tick();
        check_output("single_e1_send", tx_send, 0);
        check_output("single_e1_busy", busy, 1);
        check_output("single_e1_data", tx_data, 8'h00);
        tick();
        check_output("single_e2_send", tx_send, 1);
        check_output("single_e2_data", tx_data, 8'hA5);
        check_output("single_e2_level", level, 0);
        n = 0;
        while (!tx_active && n < 50) begin
            tick();
            n++;
        end
        check_output("single_active_seen", tx_active, 1);
        check_output("single_send_until_active", tx_send, 1);
        tick();
        check_output("single_send_fall", tx_send, 0);
        check_output("single_wait_busy", busy, 1);
        wait_idle("single_idle");
        check_output("single_end_busy", busy, 0);
        check_output("single_end_data", tx_data, 8'hA5);
        check_rx("single_rx");

        // Burst of 16 with ordering
        enable = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        check_output("burst_full", full, 1);
        check_output("burst_level", level, 16);
        check_output("burst_overflow", overflow, 0);
        enable = 1'b1;
        wait_idle("burst_idle");
        check_rx("burst_rx");

        // Overflow, clear, and set-wins-over-clear
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 8'hFD));
            push(b);
            exp_q.push_back(b);
        end
        push(8'hFF);
        check_output("ovf_set", overflow, 1);
        check_output("ovf_level", level, 16);
        check_output("ovf_full", full, 1);
        clr_ovf = 1'b1;
        push(8'hFE);
        clr_ovf = 1'b0;
        check_output("ovf_set_wins", overflow, 1);
        check_output("ovf_level2", level, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("ovf_cleared", overflow, 0);
        enable = 1'b1;
        wait_idle("ovf_idle");
        check_rx("ovf_rx");

        // Randomized bursts, never more than DEPTH outstanding
        for (int burst = 0; burst < 4; burst++) begin
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                push(b);
                exp_q.push_back(b);
                repeat ($urandom_range(0, 3)) tick();
                enable = 1'($urandom_range(0, 1));
            end
            enable = 1'b1;
            wait_idle($sformatf("rand%0d_idle", burst));
            check_output("rand_overflow", overflow, 0);
            check_output("rand_level", level, 0);
            check_rx($sformatf("rand%0d_rx", burst));
        end

        // Push and pop together while full
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'h30 + 8'(i));
            exp_q.push_back(8'h30 + 8'(i));
        end
        check_output("pp_full", full, 1);
        enable = 1'b1;
        tick();
        check_output("pp_load_busy", busy, 1);
        check_output("pp_load_send", tx_send, 0);
        push(8'h77);
        exp_q.push_back(8'h77);
        check_output("pp_level", level, 16);
        check_output("pp_full_after", full, 1);
        check_output("pp_overflow", overflow, 0);
        check_output("pp_send", tx_send, 1);
        wait_idle("pp_idle");
        check_rx("pp_rx");

        // Enable drop mid-frame, then reset while sending
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
        end
        enable = 1'b1;
        n = 0;
        while (!tx_active && n < 50) begin
            tick();
            n++;
        end
        check_output("mid_active_seen", tx_active, 1);
        tick();
        enable = 1'b0;
        check_output("mid_wait_level", level, 3);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_output("mid_idle_busy", busy, 0);
        check_output("mid_idle_level", level, 3);
        repeat (5) tick();
        check_output("mid_no_more_send", tx_send, 0);
        check_output("mid_still_idle", busy, 0);
        check_output("mid_rx_count", rx_q.size(), 1);
        check_output("mid_rx_byte", {24'd0, rx_q[0]}, {24'd0, exp_q[0]});
        enable = 1'b1;
        n = 0;
        while (!tx_send && n < 50) begin
            tick();
            n++;
        end
        check_output("mid_send_seen", tx_send, 1);
        reset_n = 1'b0;
        #1;
        check_output("arst_tx_send", tx_send, 0);
        check_output("arst_busy", busy, 0);
        check_output("arst_level", level, 0);
        check_output("arst_empty", empty, 1);
        check_output("arst_overflow", overflow, 0);
        check_output("arst_tx_data", tx_data, 8'h00);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check_output("post_rst_send", tx_send, 0);
        check_output("post_rst_busy", busy, 0);
        check_output("post_rst_rx_count", rx_q.size(), 1);
        rx_q.delete();
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte-buffering and send-sequencing stage that sits directly upstream of the UART transmitter unit. It accepts bytes from the APB register side into a FIFO. It presents one byte at a time on the transmitter's data input and asserts its send enable. It then waits on the transmitter's active/done flags before launching the next byte, so back-to-back writes are serialised without software polling.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
clock  input  1  system clock; all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  allows new bytes to be popped and launched.
wr_en  input  1  push strobe from the APB side; one byte per cycle when high.
wr_data  input  8  byte to push.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
level  output  ADDR_W+1  number of buffered entries; excludes the byte in flight.
overflow  output  1  sticky; set by a push while full.
clr_ovf  input  1  clears overflow.
busy  output  1  high whenever the FSM is not in IDLE.
tx_data  output  8  byte presented to the transmitter's data input.
tx_send  output  1  transmitter send enable.
tx_active  input  1  transmitter active flag.
tx_done  input  1  transmitter done flag.

Behaviour:
- Reset (async, reset_n=0): pointers=0, level=0, empty=1, full=0, overflow=0, tx_data=8'h00, tx_send=0, busy=0, FSM=IDLE.
- Reset mid-frame aborts sequencing immediately and discards FIFO contents. The transmitter is reset by the same reset_n.
- FIFO: circular, wr_ptr/rd_ptr ADDR_W bits, wrap from DEPTH-1 to 0. Occupancy is tracked by a separate counter 0..DEPTH.
- full/empty/level are registered and reflect the post-edge count.
- Push while full: the byte is dropped, pointers and level are unchanged, and overflow=1 on the next cycle.
- clr_ovf and an overflowing push in the same cycle: overflow stays 1 (set wins).
- Push and pop in the same cycle: both take effect and level is unchanged. This is legal even when full (the pop frees a slot first) or when empty-with-push (no pop, because a pop requires empty=0 at the sampling edge).
- FSM states:
  - IDLE: if enable=1 and empty=0, go to LOAD.
  - LOAD (1 cycle): tx_data <= mem[rd_ptr], rd_ptr++, level--; go to SEND.
  - SEND: tx_send=1. Stay until tx_active=1 is sampled, then go to WAIT_DONE with tx_send=0 from the next cycle.
  - WAIT_DONE: tx_send=0. When tx_done=1 and tx_active=0: if enable=1 and empty=0, go to LOAD; otherwise go to IDLE.
- tx_data holds stable from LOAD until the next LOAD, covering the entire frame including parity.
- A pre-existing tx_done=1 (transmitter idle) is ignored in SEND. Completion is recognised only after active has been seen.
- Latency: push into an empty FIFO with enable=1 and FSM in IDLE gives tx_send=1 exactly 3 clocks after the wr_en edge (push edge, IDLE->LOAD edge, LOAD->SEND edge).
- enable dropped mid-frame: the current frame completes normally and no further pops occur. Re-asserting enable resumes from IDLE.
- busy = (state != IDLE).
- Outputs are all registered except busy. tx_send is decoded from the state register, which makes it glitch-free.

Decomposition:
- Shared package uart_pkg: FSM state enum (IDLE, LOAD, SEND, WAIT_DONE, 2-bit encoding) and the DATA_W=8 constant.
- Natural sub-module: sync_fifo (storage, pointers, count, full/empty, overflow) instantiated by uart_tx_feeder. The FSM and handshake logic stay in the top module.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release. Required: empty=1, level=0, tx_send=0, tx_data=00, busy=0. Then tx_done=1 and tx_active=0 for 10 cycles gives no tx_send.
- Single byte: enable=1, push 8'hA5. Required: tx_send=1 on the 3rd edge after the push; tx_data=A5 held. The responder model raises tx_active 2 cycles later, and tx_send must fall the following cycle. After tx_done=1/tx_active=0, FSM returns to IDLE and busy=0.
- Burst and ordering: push 8'h01..8'h10 (16 bytes) back-to-back. Required: full=1 after the 16th push, with level=16 before the first LOAD. The transmitter model receives 01..10 in order, one tx_send per frame.
- Overflow: fill 16 with enable=0, push 8'hFF. Required: overflow=1, level=16, and FF is never transmitted. Assert clr_ovf for 1 cycle and overflow=0.
- Simultaneous push/pop at full: DEPTH entries, enable=1, push 8'h77 in the LOAD cycle. Required: level stays 16, no overflow, and 77 is transmitted last.
- Enable drop and reset mid-frame: drop enable while in WAIT_DONE with 3 bytes queued. Required: the frame completes, then IDLE with level=3. Re-enable and pull reset_n low while in SEND. Required: tx_send=0 asynchronously, level=0, overflow=0.
